// File: rtl/fp_addsub_normalize.sv
// Normalization stage of the FP add/sub datapath: leading-one detect,
// shift/adjust, carry, zero, overflow and denormal handling, 2-deep pipeline.
//
// Ports:
//   i_clk, i_rst                : clock, async active-high reset
//   i_valid/o_ready             : upstream handshake
//   i_sign, i_exp, i_man        : raw sign, pre-norm exponent, mantissa sum (+carry)
//   o_valid/i_ready             : downstream handshake
//   o_sign, o_exp, o_man        : normalized result
//   o_zero, o_denorm, o_overflow: mutually exclusive result class flags
module fp_addsub_normalize #(
    parameter int MAN_W = 24,
    parameter int EXP_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_sign,
    input  logic [EXP_W-1:0] i_exp,
    input  logic [MAN_W:0]   i_man,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_sign,
    output logic [EXP_W-1:0] o_exp,
    output logic [MAN_W-1:0] o_man,
    output logic             o_zero,
    output logic             o_denorm,
    output logic             o_overflow
);
    localparam int LZW = $clog2(MAN_W + 1);
    localparam int XW  = EXP_W + 1;
    localparam logic [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);

    logic             r_s1_valid;
    logic             r_s1_sign;
    logic [EXP_W-1:0] r_s1_exp;
    logic [MAN_W:0]   r_s1_man;
    logic [LZW-1:0]   r_s1_lzc;
    logic             r_s2_valid;

    logic             w_accept;
    logic             w_s2_en;
    logic [LZW-1:0]   w_lzc;

    logic [XW-1:0]    w_exp_x;
    logic [XW-1:0]    w_exp_inc;
    logic [XW-1:0]    w_lzc_x;
    logic [XW-1:0]    w_exp_sub;
    logic [XW-1:0]    w_shamt;
    logic             w_sign;
    logic [EXP_W-1:0] w_exp;
    logic [MAN_W-1:0] w_man;
    logic             w_zero;
    logic             w_denorm;
    logic             w_ovf;

    assign w_s2_en  = ~r_s2_valid | i_ready;
    assign o_ready  = ~r_s1_valid | ~r_s2_valid | i_ready;
    assign w_accept = i_valid & o_ready;
    assign o_valid  = r_s2_valid;

    // Leading-one position over the mantissa field (carry bit excluded).
    // Scanning upward, the last set bit seen is the most significant one.
    always_comb begin
        w_lzc = LZW'(MAN_W);
        for (int i = 0; i < MAN_W; i++) begin
            if (i_man[i]) w_lzc = LZW'(MAN_W - 1 - i);
        end
    end

    // Shift/adjust from S1. Widened exponent keeps exp+1 and exp-lzc exact.
    always_comb begin
        w_exp_x   = {1'b0, r_s1_exp};
        w_exp_inc = w_exp_x + XW'(1);
        w_lzc_x   = XW'(r_s1_lzc);
        w_exp_sub = w_exp_x - w_lzc_x;
        w_shamt   = '0;
        w_sign    = r_s1_sign;
        w_exp     = '0;
        w_man     = '0;
        w_zero    = 1'b0;
        w_denorm  = 1'b0;
        w_ovf     = 1'b0;
        if (r_s1_man[MAN_W]) begin
            if (w_exp_inc >= EXP_MAX) begin
                w_ovf = 1'b1;
                w_exp = '1;
            end else begin
                w_exp = w_exp_inc[EXP_W-1:0];
                w_man = r_s1_man[MAN_W:1];
            end
        end else if (r_s1_man == '0) begin
            w_zero = 1'b1;
            w_sign = 1'b0;
        end else if (w_exp_x > w_lzc_x) begin
            w_exp = w_exp_sub[EXP_W-1:0];
            w_man = r_s1_man[MAN_W-1:0] << r_s1_lzc;
        end else begin
            // Shift only as far as exponent 1 allows; result stays denormal.
            if (w_exp_x != '0) w_shamt = w_exp_x - XW'(1);
            w_man    = r_s1_man[MAN_W-1:0] << w_shamt;
            w_denorm = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_exp   <= '0;
            r_s1_man   <= '0;
            r_s1_lzc   <= '0;
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_sign  <= i_sign;
                r_s1_exp   <= i_exp;
                r_s1_man   <= i_man;
                r_s1_lzc   <= w_lzc;
            end else if (w_s2_en) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s2_valid <= 1'b0;
            o_sign     <= 1'b0;
            o_exp      <= '0;
            o_man      <= '0;
            o_zero     <= 1'b0;
            o_denorm   <= 1'b0;
            o_overflow <= 1'b0;
        end else if (w_s2_en) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                o_sign     <= w_sign;
                o_exp      <= w_exp;
                o_man      <= w_man;
                o_zero     <= w_zero;
                o_denorm   <= w_denorm;
                o_overflow <= w_ovf;
            end
        end
    end

endmodule
